// File: rtl/dac_tdm_pkg.sv
// Shared constants and types for the 4-slot TDM DAC transmitter.
package dac_tdm_pkg;

  localparam int unsigned N_SLOTS          = 4;
  localparam int unsigned SLOT_BITS        = 32;
  localparam int unsigned FRAME_BITS       = 128;
  localparam int unsigned LRCK_HIGH_BITS   = 64;
  localparam int unsigned STROBE_BIT       = 64;
  localparam int unsigned SAMPLE_W_DEFAULT = 16;

  typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/tdm_bit_timer.sv
// Bit-clock divider and 128-bit frame counter for the TDM transmitter.
module tdm_bit_timer
  import dac_tdm_pkg::*;
#(
  parameter int unsigned ClkPerBclk = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [6:0] bit_cnt_o,
  output logic       bclk_phase_o,
  output logic       frame_end_o,
  output logic       strobe_tick_o
);

  localparam int unsigned DivW = (ClkPerBclk > 1) ? $clog2(ClkPerBclk) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkPerBclk - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(ClkPerBclk / 2);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [6:0]      bit_cnt_q, bit_cnt_d;
  logic            div_wrap;

  always_comb begin
    div_wrap  = (div_cnt_q == DivLast);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    // 7-bit counter wraps 127 -> 0 on its own
    bit_cnt_d = div_wrap ? bit_cnt_q + 7'd1 : bit_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    bit_cnt_o     = bit_cnt_q;
    bclk_phase_o  = (div_cnt_q >= DivHalf);
    frame_end_o   = div_wrap && (bit_cnt_q == 7'(FRAME_BITS - 1));
    strobe_tick_o = (div_cnt_q == '0) && (bit_cnt_q == 7'(STROBE_BIT));
  end

endmodule

// File: rtl/dac_tdm_tx.sv
// 4-slot TDM serialiser with frame-coherent double buffering.
// Optional soft mute at frame boundaries when DAC_SOFT_MUTE_EN is defined.
module dac_tdm_tx
  import dac_tdm_pkg::*;
#(
  parameter int unsigned CLK_PER_BCLK = 2,
  parameter int unsigned SAMPLE_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] dac_in0,
  input  logic [SAMPLE_W-1:0] dac_in1,
  input  logic [SAMPLE_W-1:0] dac_in2,
  input  logic [SAMPLE_W-1:0] dac_in3,
`ifdef DAC_SOFT_MUTE_EN
  input  logic                mute,
`endif
  output logic                bclk,
  output logic                lrck,
  output logic                sdout,
  output logic                sample_strobe
);

  localparam int unsigned IdxW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  logic [6:0] bit_cnt;
  logic       bclk_phase;
  logic       frame_end;
  logic       strobe_tick;

  tdm_bit_timer #(
    .ClkPerBclk (CLK_PER_BCLK)
  ) u_bit_timer (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bit_cnt_o     (bit_cnt),
    .bclk_phase_o  (bclk_phase),
    .frame_end_o   (frame_end),
    .strobe_tick_o (strobe_tick)
  );

  logic [SAMPLE_W-1:0] dac_in   [N_SLOTS];
  logic [SAMPLE_W-1:0] shadow_q [N_SLOTS];
  logic [SAMPLE_W-1:0] shadow_d [N_SLOTS];
  logic                load_zero;

  assign dac_in[0] = dac_in0;
  assign dac_in[1] = dac_in1;
  assign dac_in[2] = dac_in2;
  assign dac_in[3] = dac_in3;

  always_comb begin
    load_zero = 1'b0;
`ifdef DAC_SOFT_MUTE_EN
    load_zero = mute;
`endif
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      shadow_d[i] = shadow_q[i];
      if (frame_end) begin
        shadow_d[i] = load_zero ? '0 : dac_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  logic [1:0]      slot;
  logic [4:0]      pos;
  logic [IdxW-1:0] bit_idx;
  logic            bclk_d, lrck_d, sdout_d, strobe_d;
  logic            bclk_q, lrck_q, sdout_q, strobe_q;

  // Samples sit MSB-first at the start of each 32-bit slot; the tail is zero padding
  always_comb begin
    slot    = bit_cnt[6:5];
    pos     = bit_cnt[4:0];
    bit_idx = IdxW'(SAMPLE_W - 1 - 32'(pos));
    sdout_d = 1'b0;
    if (32'(pos) < SAMPLE_W) begin
      sdout_d = shadow_q[slot][bit_idx];
    end
    bclk_d   = bclk_phase;
    lrck_d   = (bit_cnt < 7'(LRCK_HIGH_BITS));
    strobe_d = strobe_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      sdout_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      sdout_q  <= sdout_d;
      strobe_q <= strobe_d;
    end
  end

  assign bclk          = bclk_q;
  assign lrck          = lrck_q;
  assign sdout         = sdout_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_dac_tdm_tx.sv
// Self-checking bench for dac_tdm_tx: per-clk reference model, frame decoder and vector table.
module tb_dac_tdm_tx;
  import dac_tdm_pkg::*;

  localparam int CPB = 2;
  localparam int SW  = 16;
  localparam int FR  = CPB * 128;

  typedef struct packed {
    logic [15:0] w0, w1, w2, w3;
    logic        m;
    logic [15:0] e0, e1, e2, e3;
  } vec_t;

`ifdef DAC_SOFT_MUTE_EN
  localparam int NV = 6;
`else
  localparam int NV = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din [4];
  logic        bclk, lrck, sdout, sample_strobe;
`ifdef DAC_SOFT_MUTE_EN
  logic        mute_in = 1'b0;
`endif

  dac_tdm_tx #(
    .CLK_PER_BCLK (CPB),
    .SAMPLE_W     (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dac_in0       (din[0]),
    .dac_in1       (din[1]),
    .dac_in2       (din[2]),
    .dac_in3       (din[3]),
`ifdef DAC_SOFT_MUTE_EN
    .mute          (mute_in),
`endif
    .bclk          (bclk),
    .lrck          (lrck),
    .sdout         (sdout),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [15:0]  fw [4];
  logic         prev_lrck = 1'b0;
  logic         prev_bclk = 1'b0;
  int           rx_idx   = 128;
  int           rx_done  = 0;
  logic [127:0] rx_buf   = '0;
  logic [127:0] rx_last  = '0;
  vec_t         tbl [NV];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // One clk: compare outputs with the model for the state that preceded the edge
  task automatic step();
    int st, bitn, slot, pos;
    logic e_bclk, e_lrck, e_sd, e_stb;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_bclk", bclk, 0);
      check("rst_lrck", lrck, 0);
      check("rst_sdout", sdout, 0);
      check("rst_strobe", sample_strobe, 0);
      cyc = 0;
      for (int i = 0; i < 4; i++) fw[i] = '0;
      rx_idx = 128;
    end else begin
      st     = cyc;
      bitn   = (st / CPB) % 128;
      slot   = bitn / 32;
      pos    = bitn % 32;
      e_bclk = (st % CPB) >= CPB / 2;
      e_lrck = bitn < 64;
      e_stb  = (st % FR) == 64 * CPB;
      e_sd   = (pos < SW) ? fw[slot][SW-1-pos] : 1'b0;
      check("bclk", bclk, 32'(e_bclk));
      check("lrck", lrck, 32'(e_lrck));
      check("sdout", sdout, 32'(e_sd));
      check("strobe", sample_strobe, 32'(e_stb));
      if (st % FR == FR - 1) begin
        for (int i = 0; i < 4; i++) begin
`ifdef DAC_SOFT_MUTE_EN
          fw[i] = mute_in ? 16'h0 : din[i];
`else
          fw[i] = din[i];
`endif
        end
      end
      cyc++;
      if (!prev_lrck && lrck) rx_idx = 0;
      if (!prev_bclk && bclk && rx_idx < 128) begin
        rx_buf[127-rx_idx] = sdout;
        rx_idx++;
        if (rx_idx == 128) begin
          rx_last = rx_buf;
          rx_done++;
        end
      end
    end
    prev_lrck = lrck;
    prev_bclk = bclk;
  endtask

  task automatic wait_phase(input int ph);
    bool_found: begin
      for (int i = 0; i < FR + 2; i++) begin
        if (cyc % FR == ph) disable bool_found;
        step();
      end
      check("phase_timeout", 0, 1);
    end
  endtask

  task automatic wait_frames(input int n);
    int target;
    target = rx_done + n;
    for (int i = 0; i < (n + 2) * FR; i++) begin
      if (rx_done >= target) break;
      step();
    end
    check("frame_timeout", 32'(rx_done >= target), 1);
  endtask

  task automatic check_rx(input string nm, input logic [15:0] e0, e1, e2, e3);
    check({nm, "_s0"}, 32'(rx_last[127 -: 16]), 32'(e0));
    check({nm, "_s1"}, 32'(rx_last[95 -: 16]), 32'(e1));
    check({nm, "_s2"}, 32'(rx_last[63 -: 16]), 32'(e2));
    check({nm, "_s3"}, 32'(rx_last[31 -: 16]), 32'(e3));
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d, input logic m,
                              input logic [15:0] ea, eb, ec, ed);
    vec_t v;
    v.w0 = a;  v.w1 = b;  v.w2 = c;  v.w3 = d;  v.m = m;
    v.e0 = ea; v.e1 = eb; v.e2 = ec; v.e3 = ed;
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n, hi, stb;
    int   dummy;
    sample_t s_neg;
    for (int i = 0; i < 4; i++) begin
      din[i] = '0;
      fw[i]  = '0;
    end
    s_neg  = -16'sd2;
    tbl[0] = mk(16'h8001, 16'h0000, 16'h0000, 16'h0000, 0, 16'h8001, 16'h0000, 16'h0000, 16'h0000);
    tbl[1] = mk(16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h1234, 0, 16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h1234);
    tbl[2] = mk(16'h8000, 16'h7FFF, 16'h0001, s_neg, 0, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE);
    tbl[3] = mk(16'h5555, 16'hAAAA, 16'hC3C3, 16'h0000, 0, 16'h5555, 16'hAAAA, 16'hC3C3, 16'h0000);
    tbl[4] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
`ifdef DAC_SOFT_MUTE_EN
    tbl[5] = mk(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`endif

    // Reset and first edges
    repeat (10) step();
    rst_n = 1'b1;
    step();
    check("first_lrck", lrck, 1);
    check("first_bclk", bclk, 0);
    step();
    check("second_bclk", bclk, 1);

    // Vector table: words set mid-frame appear in the frame after the next latch
    for (int v = 0; v < NV; v++) begin
      wait_phase(20);
      din[0] = tbl[v].w0;
      din[1] = tbl[v].w1;
      din[2] = tbl[v].w2;
      din[3] = tbl[v].w3;
`ifdef DAC_SOFT_MUTE_EN
      mute_in = tbl[v].m;
`endif
      wait_frames(2);
      check_rx($sformatf("vec%0d", v), tbl[v].e0, tbl[v].e1, tbl[v].e2, tbl[v].e3);
    end
`ifdef DAC_SOFT_MUTE_EN
    mute_in = 1'b0;
`endif

    // lrck duty and strobe count over one full frame
    wait_phase(0);
    hi  = 0;
    stb = 0;
    for (int i = 0; i < FR; i++) begin
      step();
      hi  += int'(lrck);
      stb += int'(sample_strobe);
    end
    check("lrck_high_clks", 32'(hi), 128);
    check("strobes_per_frame", 32'(stb), 1);

    // Input change mid-frame does not disturb the frame in flight
    wait_phase(20);
    din[0] = 16'h1111; din[1] = 16'h0; din[2] = 16'h0; din[3] = 16'h0;
    wait_frames(2);
    check("coh_first", 32'(rx_last[127 -: 16]), 32'h1111);
    wait_phase(20);
    din[0] = 16'h2222;
    wait_frames(1);
    check("coh_current", 32'(rx_last[127 -: 16]), 32'h1111);
    wait_frames(1);
    check("coh_next", 32'(rx_last[127 -: 16]), 32'h2222);

    // Strobe spacing
    n = 0;
    for (int i = 0; i < FR + 4; i++) begin
      step();
      if (sample_strobe) break;
    end
    for (int i = 0; i < FR + 4; i++) begin
      step();
      n++;
      if (sample_strobe) break;
    end
    check("strobe_period", 32'(n), 32'(FR));

    // Asynchronous reset at bit 40, then restart from bit 0
    wait_phase(80);
    #1 rst_n = 1'b0;
    #1;
    check("async_bclk", bclk, 0);
    check("async_lrck", lrck, 0);
    check("async_sdout", sdout, 0);
    check("async_strobe", sample_strobe, 0);
    repeat (10) step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < FR + 4; i++) begin
      step();
      n++;
      if (sample_strobe) break;
    end
    check("strobe_after_reset", 32'(n), 32'(64 * CPB + 1));

`ifdef DAC_SOFT_MUTE_EN
    // Mute is applied only at frame latches
    wait_phase(20);
    for (int i = 0; i < 4; i++) din[i] = 16'h7FFF;
    wait_frames(2);
    check_rx("mute_pre", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_phase(60);
    mute_in = 1'b1;
    wait_frames(1);
    check_rx("mute_cur", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_frames(1);
    check_rx("mute_on", 16'h0, 16'h0, 16'h0, 16'h0);
    wait_phase(60);
    mute_in = 1'b0;
    wait_frames(1);
    check_rx("unmute_cur", 16'h0, 16'h0, 16'h0, 16'h0);
    wait_frames(1);
    check_rx("unmute_next", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
`endif

    // Randomised inputs changing at random clks, checked against the per-clk model
    for (int f = 0; f < 12; f++) begin
      n = int'($urandom_range(1, 300));
      repeat (n) step();
      for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
`ifdef DAC_SOFT_MUTE_EN
      mute_in = ($urandom_range(0, 3) == 0);
`endif
    end
    dummy = 0;
    repeat (FR * 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_tdm_tx.md
Name: dac_tdm_tx

Overview:
- Serialises the four calibrated DAC words (the dac_out0..3 outputs of the output calibrator) onto a 4-slot TDM link to the audio codec DAC.
- Generates the codec bit clock and frame clock, and double-buffers the samples so that each frame is coherent.
- Produces sample_strobe, a once-per-frame pulse that drives the upstream sample_clk. The calibration pipeline is therefore refreshed mid-frame and is settled before the next frame latch.

Parameters:
- CLK_PER_BCLK, 2: clk cycles per bclk period; even, ≥2. Frame length = CLK_PER_BCLK*128 clk cycles (256 at default, 46.875 kHz from 12 MHz).
- SAMPLE_W, 16: sample width; MSB-first, left-justified in a 32-bit slot.

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  reset, asynchronous, active-low
- dac_in0  in  SAMPLE_W  signed sample, slot 0
- dac_in1  in  SAMPLE_W  signed sample, slot 1
- dac_in2  in  SAMPLE_W  signed sample, slot 2
- dac_in3  in  SAMPLE_W  signed sample, slot 3
- bclk  out  1  codec bit clock
- lrck  out  1  codec frame clock, 50% duty
- sdout  out  1  TDM serial data
- sample_strobe  out  1  one-clk pulse per frame; upstream sample clock
- mute  in  1  present only with DAC_SOFT_MUTE_EN (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- State registers:
  - div_cnt: 0..CLK_PER_BCLK-1, increments every clk and wraps.
  - bit_cnt: 7 bits, 0..127; increments when div_cnt wraps, wraps 127→0.
  - slot = bit_cnt[6:5]; pos = bit_cnt[4:0].
- All outputs are registered from the current state (one-clk lag, identical for every output):
  - bclk <= (div_cnt >= CLK_PER_BCLK/2). Low in the first half of each bit period, high in the second. The codec samples sdout on the bclk rising edge.
  - lrck <= (bit_cnt < 64). Frame begins at the lrck rising edge.
  - sdout <= (pos < SAMPLE_W) ? shadow[slot][SAMPLE_W-1-pos] : 0.
  - sdout and lrck change only at bclk falling edges.
- Frame latch: at bit_cnt==127 and div_cnt==CLK_PER_BCLK-1, shadow[0..3] <= dac_in0..3 on the same edge that bit_cnt wraps to 0. Bit 0 of the new frame uses the new samples.
  - Input changes at any other time have no effect on the frame being sent.
- sample_strobe is 1 for exactly one clk, on the clk where bit_cnt==64 and div_cnt==0. Otherwise 0.
  - Period: CLK_PER_BCLK*128 clks.
  - Upstream gets 64 bit periods (≥128 clks) to settle before the next latch.
- Reset values, forced asynchronously while rst_n=0: bclk=0, lrck=0, sdout=0, sample_strobe=0, div_cnt=0, bit_cnt=0, shadow=0.
- After rst_n deasserts:
  - First clk edge: lrck=1, bclk=0.
  - The first frame transmits zeros (shadow=0).
  - The first latch occurs at the end of that frame.
- Reset asserted mid-frame: outputs go to reset values immediately; the frame is abandoned and restarts at bit 0 after release. No partial strobe.
- Negative samples are transmitted as raw two's complement; no saturation (the upstream block clamps).

Optional Feature:
- Macro: DAC_SOFT_MUTE_EN.
- Defined:
  - Port mute exists.
  - At each frame latch, if mute==1, shadow[0..3] <= 0 instead of dac_in. Mute takes effect on frame boundaries only.
  - mute toggling mid-frame does not alter the current frame.
- Undefined: no mute port; the latch always loads dac_in.

Decomposition:
- Package dac_tdm_pkg:
  - N_SLOTS=4, SLOT_BITS=32, FRAME_BITS=128, LRCK_HIGH_BITS=64, STROBE_BIT=64.
  - typedef sample_t (signed [SAMPLE_W-1:0]).
- Sub-module tdm_bit_timer (div_cnt/bit_cnt counters):
  - Outputs bit_cnt, a bclk-phase flag, frame_end and strobe_tick.
  - dac_tdm_tx holds the shadow registers and output registers.

Test Plan:
1. Reset: hold rst_n=0 for 10 clks -> all outputs 0. Release -> first edge lrck=1, bclk=0; bclk rises on the 2nd edge; sdout=0 throughout frame 0.
2. dac_in0=16'h8001, others 0, held -> in frame 1, slot-0 sdout = 1,0×14,1, then 16 zeros; slots 1–3 all zero; lrck high for exactly 128 clks, low 128.
3. dac_in0..3 = 16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h1234 -> the sampled bitstream, captured on bclk rises, decodes back to those four words in slot order.
4. Change dac_in0 from 16'h1111 to 16'h2222 at bit_cnt=10 -> the current frame carries 16'h1111; the next frame carries 16'h2222.
5. sample_strobe -> one-clk wide, 256 clks apart, coincident with lrck's falling edge region (bit 64). rst_n=0 at bit 40 -> outputs 0 immediately; after release, no strobe until bit 64 of the new frame.
6. (DAC_SOFT_MUTE_EN) dac_in=16'h7FFF on all slots, mute=1 asserted mid-frame -> the current frame is still 16'h7FFF; the following frames are all zero; deasserting mute restores 16'h7FFF from the next latch.
